// File: rtl/hash_checker_pkg.sv
// Shared types and constants for the digest checker: FSM state encoding and
// the Blake2 digest lengths.
package hash_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BLAKE2S_BYTES = 32;
  localparam int BLAKE2B_BYTES = 64;

endpackage

// File: rtl/hash_checker_byte_mux.sv
// Selects expected digest byte [8*sel +: 8]; out-of-range selects return 0.
module byte_mux #(
  parameter int HASH_BYTES = 32,
  parameter int CNT_W      = 7
) (
  input  logic [8*HASH_BYTES-1:0] data,
  input  logic [CNT_W-1:0]        sel,
  output logic [7:0]              q
);

  always_comb begin
    q = '0;
    for (int unsigned k = 0; k < HASH_BYTES; k++) begin
      if (sel == CNT_W'(k)) q = data[8*k +: 8];
    end
  end

endmodule

// File: rtl/hash_checker.sv
// Captures the serial digest stream while hash_v_i is high and compares it
// byte-by-byte against exp_hash_i, reporting a registered verdict.
module hash_checker
  import hash_checker_pkg::*;
#(
  parameter int HASH_BYTES = BLAKE2S_BYTES,
  parameter int TIMEOUT_W  = 16,
  parameter int CNT_W      = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [8*HASH_BYTES-1:0] exp_hash_i,
  input  logic [7:0]              hash_i,
  input  logic                    hash_v_i,
  output logic                    done_o,
  output logic                    match_o,
  output logic                    len_err_o,
  output logic                    timeout_o,
  output logic [CNT_W-1:0]        byte_cnt_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HASH_BYTES - 1);

  state_t                 state, state_nxt;
  logic [TIMEOUT_W-1:0]   timer, timer_nxt, timer_inc;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   mismatch, mis_nxt;
  logic                   len_nxt, to_nxt, done_nxt, match_nxt;
  logic [7:0]             exp_byte;

  byte_mux #(
    .HASH_BYTES(HASH_BYTES),
    .CNT_W     (CNT_W)
  ) u_byte_mux (
    .data(exp_hash_i),
    .sel (byte_cnt_o),
    .q   (exp_byte)
  );

  assign timer_inc = timer + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_i) begin
      state_nxt = WAIT;
    end else begin
      case (state)
        WAIT: begin
          if (hash_v_i)              state_nxt = (HASH_BYTES == 1) ? DONE : RECV;
          else if (timer_inc == '1)  state_nxt = DONE;
        end
        RECV: begin
          if (!hash_v_i || byte_cnt_o == LAST_IDX) state_nxt = DONE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Next values of the registered datapath and outputs; the verdict is
  // derived from next-state flags so it lands on the capture edge itself.
  always_comb begin
    timer_nxt = timer;
    cnt_nxt   = byte_cnt_o;
    mis_nxt   = mismatch;
    len_nxt   = len_err_o;
    to_nxt    = timeout_o;
    if (start_i) begin
      timer_nxt = '0;
      cnt_nxt   = '0;
      mis_nxt   = 1'b0;
      len_nxt   = 1'b0;
      to_nxt    = 1'b0;
    end else begin
      case (state)
        WAIT, RECV: begin
          if (state == WAIT) timer_nxt = timer_inc;
          if (hash_v_i) begin
            mis_nxt = mismatch | (hash_i != exp_byte);
            cnt_nxt = byte_cnt_o + 1'b1;
          end else if (state == RECV) begin
            len_nxt = 1'b1;
          end else if (timer_inc == '1) begin
            to_nxt = 1'b1;
          end
        end
        DONE: begin
          if (hash_v_i) begin
            len_nxt = 1'b1;
            if (byte_cnt_o != '1) cnt_nxt = byte_cnt_o + 1'b1;
          end
        end
        default: ;
      endcase
    end
    done_nxt  = (state_nxt == DONE);
    match_nxt = done_nxt & ~mis_nxt & ~len_nxt & ~to_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer      <= '0;
      mismatch   <= 1'b0;
      byte_cnt_o <= '0;
      len_err_o  <= 1'b0;
      timeout_o  <= 1'b0;
      done_o     <= 1'b0;
      match_o    <= 1'b0;
    end else begin
      timer      <= timer_nxt;
      mismatch   <= mis_nxt;
      byte_cnt_o <= cnt_nxt;
      len_err_o  <= len_nxt;
      timeout_o  <= to_nxt;
      done_o     <= done_nxt;
      match_o    <= match_nxt;
    end
  end

endmodule

// File: tb/tb_hash_checker.sv
// Self-checking bench for hash_checker: directed scenarios plus randomized
// transactions checked against a transaction-level verdict model.
module tb_hash_checker;

  localparam int HB  = 32;
  localparam int TW  = 4;
  localparam int CW  = 7;
  localparam int TMO = (1 << TW) - 1;

  typedef struct packed {
    logic          done;
    logic          match;
    logic          len_err;
    logic          timeout;
    logic [CW-1:0] cnt;
  } verdict_t;

  logic            clk = 1'b0;
  logic            rst, start_i, hash_v_i;
  logic [7:0]      hash_i;
  logic [8*HB-1:0] exp_hash_i;
  logic            done_o, match_o, len_err_o, timeout_o;
  logic [CW-1:0]   byte_cnt_o;

  logic [7:0] exp_b [0:HB-1];
  logic [7:0] tx    [0:159];

  int checks = 0;
  int errors = 0;

  hash_checker #(
    .HASH_BYTES(HB),
    .TIMEOUT_W (TW),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .exp_hash_i(exp_hash_i),
    .hash_i    (hash_i),
    .hash_v_i  (hash_v_i),
    .done_o    (done_o),
    .match_o   (match_o),
    .len_err_o (len_err_o),
    .timeout_o (timeout_o),
    .byte_cnt_o(byte_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp();
    for (int k = 0; k < HB; k++) exp_hash_i[8*k +: 8] = exp_b[k];
  endtask

  task automatic arm();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // gap idle cycles, then n contiguous valid bytes from tx[], then two idle cycles
  task automatic send(input int gap, input int n);
    hash_v_i = 1'b0;
    repeat (gap) tick();
    for (int i = 0; i < n; i++) begin
      hash_v_i = 1'b1;
      hash_i   = tx[i];
      tick();
    end
    hash_v_i = 1'b0;
    hash_i   = 8'($urandom);
    tick();
    tick();
  endtask

  // Expected final verdict of one armed transaction
  function automatic verdict_t model(input int gap, input int n);
    verdict_t v;
    logic     bad;
    v = '0;
    v.done = 1'b1;
    if (gap >= TMO) begin
      v.timeout = 1'b1;
      return v;
    end
    bad = 1'b0;
    for (int k = 0; k < n && k < HB; k++) bad |= (tx[k] != exp_b[k]);
    v.cnt     = CW'((n > 127) ? 127 : n);
    v.len_err = (n != HB);
    v.match   = !bad && !v.len_err;
    return v;
  endfunction

  task automatic set_ascending();
    for (int k = 0; k < HB; k++) exp_b[k] = 8'(k);
    load_exp();
    for (int k = 0; k < 160; k++) tx[k] = (k < HB) ? 8'(k) : 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; hash_v_i = 1'b0; hash_i = '0; exp_hash_i = '0;
    repeat (3) tick();
    checks++;
    if ({done_o, match_o, len_err_o, timeout_o, byte_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {done_o, match_o, len_err_o, timeout_o, byte_cnt_o});
    end
    start_i = 1'b1;
    tick();
    rst = 1'b0; start_i = 1'b0; hash_v_i = 1'b1;
    tick();
    hash_v_i = 1'b0;
    checks++;
    if (byte_cnt_o !== 0) begin
      errors++;
      $display("FAIL reset_beats_start: byte_cnt got %0d required 0", byte_cnt_o);
    end
  endtask

  task automatic test_match();
    set_ascending();
    arm();
    for (int i = 0; i < HB; i++) begin
      hash_v_i = 1'b1;
      hash_i   = tx[i];
      tick();
      if (i == HB - 2) begin
        checks++;
        if (done_o !== 1'b0) begin
          errors++;
          $display("FAIL match_early_done: done got %b required 0", done_o);
        end
      end
    end
    hash_v_i = 1'b0;
    checks++;
    if ({done_o, match_o, len_err_o, byte_cnt_o} !== {1'b1, 1'b1, 1'b0, CW'(HB)}) begin
      errors++;
      $display("FAIL match_verdict: done/match/len_err/cnt got %b/%b/%b/%0d required 1/1/0/32",
               done_o, match_o, len_err_o, byte_cnt_o);
    end
    tick();
    checks++;
    if ({done_o, match_o} !== 2'b11) begin
      errors++;
      $display("FAIL match_hold: done/match got %b/%b required 1/1", done_o, match_o);
    end
  endtask

  task automatic test_mismatch();
    set_ascending();
    tx[17] = 8'hAA;
    arm();
    send(0, HB);
    checks++;
    if ({done_o, match_o, len_err_o, byte_cnt_o} !== {1'b1, 1'b0, 1'b0, CW'(HB)}) begin
      errors++;
      $display("FAIL mismatch_verdict: done/match/len_err/cnt got %b/%b/%b/%0d required 1/0/0/32",
               done_o, match_o, len_err_o, byte_cnt_o);
    end
  endtask

  task automatic test_early_drop();
    set_ascending();
    arm();
    for (int i = 0; i < 20; i++) begin
      hash_v_i = 1'b1;
      hash_i   = tx[i];
      tick();
    end
    hash_v_i = 1'b0;
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_before_edge: done got %b required 0", done_o);
    end
    tick();
    checks++;
    if ({done_o, match_o, len_err_o, byte_cnt_o} !== {1'b1, 1'b0, 1'b1, CW'(20)}) begin
      errors++;
      $display("FAIL drop_verdict: done/match/len_err/cnt got %b/%b/%b/%0d required 1/0/1/20",
               done_o, match_o, len_err_o, byte_cnt_o);
    end
  endtask

  task automatic test_overrun();
    set_ascending();
    arm();
    send(0, HB + 2);
    checks++;
    if ({done_o, match_o, len_err_o, byte_cnt_o} !== {1'b1, 1'b0, 1'b1, CW'(34)}) begin
      errors++;
      $display("FAIL overrun_verdict: done/match/len_err/cnt got %b/%b/%b/%0d required 1/0/1/34",
               done_o, match_o, len_err_o, byte_cnt_o);
    end
    arm();
    send(0, 140);
    checks++;
    if (byte_cnt_o !== CW'(127)) begin
      errors++;
      $display("FAIL overrun_saturate: byte_cnt got %0d required 127", byte_cnt_o);
    end
  endtask

  task automatic test_timeout();
    hash_v_i = 1'b0;
    arm();
    repeat (TMO - 1) tick();
    checks++;
    if ({done_o, timeout_o} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_early: done/timeout got %b/%b required 0/0", done_o, timeout_o);
    end
    tick();
    checks++;
    if ({done_o, match_o, timeout_o, len_err_o} !== 4'b1010) begin
      errors++;
      $display("FAIL timeout_verdict: done/match/timeout/len_err got %b/%b/%b/%b required 1/0/1/0",
               done_o, match_o, timeout_o, len_err_o);
    end
    arm();
    checks++;
    if ({done_o, match_o, len_err_o, timeout_o, byte_cnt_o} !== '0) begin
      errors++;
      $display("FAIL timeout_rearm: flags got %b required all zero",
               {done_o, match_o, len_err_o, timeout_o, byte_cnt_o});
    end
  endtask

  task automatic test_restart();
    set_ascending();
    arm();
    for (int i = 0; i < 10; i++) begin
      hash_v_i = 1'b1;
      hash_i   = tx[i];
      tick();
    end
    start_i  = 1'b1;
    hash_i   = tx[10];
    tick();
    start_i  = 1'b0;
    checks++;
    if ({done_o, byte_cnt_o} !== {1'b0, CW'(0)}) begin
      errors++;
      $display("FAIL restart_rearm: done/cnt got %b/%0d required 0/0", done_o, byte_cnt_o);
    end
    for (int i = 0; i < 3; i++) begin
      hash_i = tx[i];
      tick();
    end
    checks++;
    if (byte_cnt_o !== CW'(3)) begin
      errors++;
      $display("FAIL restart_capture: byte_cnt got %0d required 3", byte_cnt_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({done_o, match_o, len_err_o, timeout_o, byte_cnt_o} !== '0) begin
      errors++;
      $display("FAIL restart_reset: outputs got %b required all zero",
               {done_o, match_o, len_err_o, timeout_o, byte_cnt_o});
    end
    tick();
    hash_v_i = 1'b0;
    checks++;
    if ({done_o, byte_cnt_o} !== {1'b0, CW'(0)}) begin
      errors++;
      $display("FAIL idle_no_capture: done/cnt got %b/%0d required 0/0", done_o, byte_cnt_o);
    end
  endtask

  task automatic test_random();
    verdict_t exp_v, got_v;
    int gap, n, idx, sel;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < HB; k++) exp_b[k] = 8'($urandom);
      load_exp();
      for (int k = 0; k < 160; k++) tx[k] = (k < HB) ? exp_b[k] : 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        idx     = $urandom_range(0, HB - 1);
        tx[idx] = exp_b[idx] ^ 8'($urandom_range(1, 255));
      end
      gap = $urandom_range(0, TMO + 3);
      sel = $urandom_range(0, 3);
      if (gap >= TMO)    n = 0;
      else if (sel == 0) n = $urandom_range(1, HB - 1);
      else if (sel == 3) n = $urandom_range(HB + 1, HB + 8);
      else               n = HB;
      exp_v = model(gap, n);
      arm();
      send(gap, n);
      got_v = {done_o, match_o, len_err_o, timeout_o, byte_cnt_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random_txn[%0d] gap=%0d n=%0d: done/match/len/to/cnt got %b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
                 it, gap, n, got_v.done, got_v.match, got_v.len_err, got_v.timeout, got_v.cnt,
                 exp_v.done, exp_v.match, exp_v.len_err, exp_v.timeout, exp_v.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_early_drop();
    test_overrun();
    test_timeout();
    test_restart();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
